// File: rtl/sram_device_emu.sv
// Cycle-quantised model of an asynchronous SRAM seen from the controller's pins:
// read access/hold/high-Z timing, write-pulse and data-setup checking.
module sram_device_emu #(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned CLK_PERIOD_NS = 5,
    parameter int unsigned TAA_NS        = 45,
    parameter int unsigned TOHA_NS       = 10,
    parameter int unsigned TDOE_NS       = 22,
    parameter int unsigned TLZOE_NS      = 5,
    parameter int unsigned THZOE_NS      = 18,
    parameter int unsigned TPWE_NS       = 35,
    parameter int unsigned TSD_NS        = 25
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] sram_addr_i,
    input  logic              sram_ce_n_i,
    input  logic              sram_oe_n_i,
    input  logic              sram_we_n_i,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe_o,
    output logic              dq_valid_o,
    output logic [2:0]        timing_err_o,
    input  logic              err_clr_i
);
    localparam int unsigned TAA_C   = (TAA_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int unsigned TOHA_C  = (TOHA_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int unsigned TDOE_C  = (TDOE_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int unsigned TLZOE_C = (TLZOE_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int unsigned THZOE_C = (THZOE_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int unsigned TPWE_C  = (TPWE_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int unsigned TSD_C   = (TSD_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;

    localparam int unsigned ADDR_SAT = (TAA_C > TOHA_C + 1) ? TAA_C : TOHA_C + 1;
    localparam int unsigned OE_SAT   = (TDOE_C > TLZOE_C) ? TDOE_C : TLZOE_C;
    localparam int unsigned MAX_A    = (ADDR_SAT > OE_SAT) ? ADDR_SAT : OE_SAT;
    localparam int unsigned MAX_B    = (TPWE_C > TSD_C) ? TPWE_C : TSD_C;
    localparam int unsigned MAX_AB   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_C    = (MAX_AB > THZOE_C) ? MAX_AB : THZOE_C;
    localparam int unsigned CNT_W    = $clog2(MAX_C + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t TAA_T    = cnt_t'(TAA_C);
    localparam cnt_t TOHA_T   = cnt_t'(TOHA_C);
    localparam cnt_t TDOE_T   = cnt_t'(TDOE_C);
    localparam cnt_t TLZOE_T  = cnt_t'(TLZOE_C);
    localparam cnt_t THZOE_T  = cnt_t'(THZOE_C);
    localparam cnt_t TPWE_T   = cnt_t'(TPWE_C);
    localparam cnt_t TSD_T    = cnt_t'(TSD_C);
    localparam cnt_t ADDR_SAT_T = cnt_t'(ADDR_SAT);
    localparam cnt_t OE_SAT_T   = cnt_t'(OE_SAT);

    if (TAA_C < 1 || TOHA_C < 1 || TDOE_C < 1 || TLZOE_C < 1 || THZOE_C < 1 ||
        TPWE_C < 1 || TSD_C < 1) begin : g_bad_timing
        $error("sram_device_emu: every derived timing count must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StRead, StReadHz, StWrite} state_e;

    function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
        return (v >= lim) ? lim : v + cnt_t'(1);
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_prev_q, waddr_q, waddr_d;
    logic [DATA_W-1:0] dq_prev_q, wdata_q, wdata_d;
    cnt_t              addr_cnt_q, addr_cnt_d, oe_cnt_q, oe_cnt_d;
    cnt_t              pwe_cnt_q, pwe_cnt_d, sd_cnt_q, sd_cnt_d, hz_cnt_q, hz_cnt_d;
    logic              waddr_chg_q, waddr_chg_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic              dq_oe_q, dq_oe_d, valid_q, valid_d;
    logic [2:0]        err_q, err_d, new_err;
    logic              commit;
    logic              read_active, write_active;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign read_active  = !sram_ce_n_i && !sram_oe_n_i && sram_we_n_i;
    assign write_active = !sram_ce_n_i && !sram_we_n_i;

    // Counters hold the number of sampled edges the condition has held, this edge included.
    always_comb begin
        addr_cnt_d = (sram_addr_i != addr_prev_q) ? cnt_t'(1) : sat_inc(addr_cnt_q, ADDR_SAT_T);
        oe_cnt_d   = read_active ? sat_inc(oe_cnt_q, OE_SAT_T) : '0;
        pwe_cnt_d  = write_active ? sat_inc(pwe_cnt_q, TPWE_T) : '0;
        sd_cnt_d   = '0;
        if (write_active) begin
            sd_cnt_d = (sram_dq_i != dq_prev_q) ? cnt_t'(1) : sat_inc(sd_cnt_q, TSD_T);
        end
    end

    always_comb begin
        state_d     = state_q;
        hz_cnt_d    = '0;
        waddr_d     = waddr_q;
        wdata_d     = write_active ? sram_dq_i : wdata_q;
        waddr_chg_d = waddr_chg_q;
        new_err     = '0;
        commit      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (write_active)     state_d = StWrite;
                else if (read_active) state_d = StRead;
            end
            StRead: begin
                if (write_active) state_d = StWrite;
                else if (!read_active) begin
                    state_d  = StReadHz;
                    hz_cnt_d = cnt_t'(1);
                end
            end
            StReadHz: begin
                if (write_active)              state_d = StWrite;
                else if (read_active)          state_d = StRead;
                else if (hz_cnt_q >= THZOE_T)  state_d = StIdle;
                else                           hz_cnt_d = hz_cnt_q + cnt_t'(1);
            end
            StWrite: begin
                if (write_active) begin
                    if (sram_addr_i != waddr_q) waddr_chg_d = 1'b1;
                end else begin
                    new_err[0] = pwe_cnt_q < TPWE_T;
                    new_err[1] = sd_cnt_q < TSD_T;
                    new_err[2] = waddr_chg_q;
                    commit     = (new_err == 3'b000);
                    state_d    = read_active ? StRead : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StWrite && state_q != StWrite) begin
            waddr_d     = sram_addr_i;
            waddr_chg_d = 1'b0;
        end
        err_d = (err_clr_i ? 3'b000 : err_q) | new_err;
    end

    always_comb begin
        dq_d    = '0;
        dq_oe_d = 1'b0;
        valid_d = 1'b0;
        case (state_d)
            StRead: begin
                dq_oe_d = (oe_cnt_d >= TLZOE_T);
                if (addr_cnt_d >= TAA_T && oe_cnt_d >= TDOE_T) begin
                    valid_d = 1'b1;
                    dq_d    = mem[sram_addr_i];
                end else if (valid_q && addr_cnt_d <= TOHA_T) begin
                    // Output hold: previous word survives an address change briefly.
                    valid_d = 1'b1;
                    dq_d    = dq_q;
                end
            end
            StReadHz: begin
                dq_d    = dq_q;
                dq_oe_d = dq_oe_q;
                valid_d = valid_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            addr_prev_q <= '0;
            dq_prev_q   <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            waddr_chg_q <= 1'b0;
            addr_cnt_q  <= '0;
            oe_cnt_q    <= '0;
            pwe_cnt_q   <= '0;
            sd_cnt_q    <= '0;
            hz_cnt_q    <= '0;
            dq_q        <= '0;
            dq_oe_q     <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_prev_q <= sram_addr_i;
            dq_prev_q   <= sram_dq_i;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            waddr_chg_q <= waddr_chg_d;
            addr_cnt_q  <= addr_cnt_d;
            oe_cnt_q    <= oe_cnt_d;
            pwe_cnt_q   <= pwe_cnt_d;
            sd_cnt_q    <= sd_cnt_d;
            hz_cnt_q    <= hz_cnt_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (commit) mem[waddr_q] <= wdata_q;
    end

    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign dq_valid_o   = valid_q;
    assign timing_err_o = err_q;

endmodule

// File: doc/sram_device_emu.md
Name: sram_device_emu

Overview:
- Clock-sampled emulation of the asynchronous SRAM device that sits on the far side of our SRAM controller's pin interface.
- It samples the controller-driven pins (CE#, OE#, WE#, address, write data) on a fast sample clock.
- It answers reads with datasheet-accurate latency, quantised to clock cycles, and commits writes only when the write-pulse and data-setup timing is met.
- Used in FPGA-in-loop and simulation benches to close the loop on the controller. It also flags timing violations.

Parameters:
- ADDR_W, 10, address width; the array is 2**ADDR_W words.
- DATA_W, 16, data width.
- CLK_PERIOD_NS, 5, sample clock period in ns.
- TAA_NS, 45, address-to-data time. Default from sram_timings_pkg.
- TOHA_NS, 10, output hold after an address change.
- TDOE_NS, 22, OE#-to-data time.
- TLZOE_NS, 5, OE#-to-low-Z time.
- THZOE_NS, 18, OE#-to-high-Z time.
- TPWE_NS, 35, minimum WE# pulse width.
- TSD_NS, 25, data setup before the end of the write.
- Derived cycle counts: X_C = ceil(X_NS / CLK_PERIOD_NS).
  - Defaults: TAA_C=9, TOHA_C=2, TDOE_C=5, TLZOE_C=1, THZOE_C=4, TPWE_C=7, TSD_C=5.
  - Every X_C must be at least 1; elaboration fails otherwise.

Ports:
- clk_i  in  1  sample clock.
- rst_n_i  in  1  asynchronous active-low reset.
- sram_addr_i  in  ADDR_W  address pins.
- sram_ce_n_i  in  1  chip enable, active low.
- sram_oe_n_i  in  1  output enable, active low.
- sram_we_n_i  in  1  write enable, active low.
- sram_dq_i  in  DATA_W  data bus as driven by the controller.
- sram_dq_o  out  DATA_W  data driven by the device.
- sram_dq_oe_o  out  1  device drives the bus.
- dq_valid_o  out  1  sram_dq_o holds valid array data (bench-only).
- timing_err_o  out  3  sticky error flags: [0] tPWE, [1] tSD, [2] address changed during write.
- err_clr_i  in  1  clears timing_err_o.

Behaviour:
- Reset: the asynchronous assert of rst_n_i sets every output to 0, sets all counters to 0, and forces state IDLE. Array contents are not reset. A write in progress when reset asserts is discarded.
- All pin inputs are synchronous to clk_i; the bench or an upstream synchroniser is responsible for that.
- All outputs are registered.
- Counters increment on each edge while their condition holds and saturate at their maximum threshold:
  - addr_cnt clears when sram_addr_i differs from its previous sample.
  - oe_cnt counts cycles of read_active = !ce_n & !oe_n & we_n.
  - pwe_cnt counts cycles of write_active = !ce_n & !we_n.
  - sd_cnt clears when sram_dq_i changes during write_active.
- State machine, states IDLE, READ, READ_HZ, WRITE:
  - IDLE -> WRITE on write_active; IDLE -> READ on read_active. Write has priority in every state.
  - READ:
    - sram_dq_oe_o rises once oe_cnt >= TLZOE_C.
    - dq_valid_o=1 and sram_dq_o=mem[addr] once addr_cnt >= TAA_C and oe_cnt >= TDOE_C.
    - On an address change, the previous word and dq_valid_o=1 are held for TOHA_C edges. After that, dq_valid_o=0 and sram_dq_o=0 until the new access completes.
    - When read_active drops, go to READ_HZ.
  - READ_HZ:
    - sram_dq_o/sram_dq_oe_o are held for THZOE_C edges, then oe drops and dq_valid_o drops, returning to IDLE.
    - Re-entry into read_active goes back to READ with oe_cnt restarting.
  - WRITE:
    - sram_dq_oe_o=0 and dq_valid_o=0 from the first edge. The address is latched on entry. The data word is captured every cycle.
    - On exit (we_n or ce_n high):
      - If pwe_cnt >= TPWE_C and sd_cnt >= TSD_C and no address change occurred, mem[latched addr] is written with the last captured word.
      - Otherwise the array is untouched and the matching error bits are set.
    - Next state is READ if read_active holds, else IDLE.
- timing_err_o bits are sticky OR-set.
- err_clr_i clears the bits; a new error in the same cycle wins.
- Back-to-back writes with no idle cycle are not possible: WE# must rise, and that rise ends the access.

Test Plan:
- Correct write: write 0xBEEF to 0x012 with WE# low for 7 cycles, data stable for 7 cycles. Then drive CE#/OE# low and addr=0x012 on the same edge. Required: sram_dq_oe_o=1 after 1 edge, dq_valid_o=1 with 0xBEEF after 9 edges, timing_err_o=0.
- Address change during read: change addr to 0x013, which holds 0x1234. Required: 0xBEEF held with valid for 2 edges, then valid=0, then 0x1234 valid 9 edges after the change.
- OE# release: raise OE#. Required: sram_dq_oe_o stays 1 for 4 edges then 0; dq_valid_o falls with it.
- Short write pulse: WE# low 6 cycles writing 0x5555 to 0x012. Required: timing_err_o=3'b001 and readback returns 0xBEEF.
- Late data: WE# low 8 cycles with data changed 3 cycles before the end. Required: timing_err_o[1]=1 and no commit. Then pulse err_clr_i: required timing_err_o=0 on the next edge.
- Reset mid-write: assert rst_n_i low during a valid-length write. Required: all outputs 0 immediately, state IDLE, and the target word unchanged.
